// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN inference pipeline: phase codes, counter width
// and timing defaults used by the sequencer and the layer engines.
package bnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_LOAD    = 3'b001,
        ST_LAYER_1 = 3'b010,
        ST_LAYER_2 = 3'b011,
        ST_LAYER_3 = 3'b100,
        ST_DONE    = 3'b101,
        ST_ERROR   = 3'b110
    } bnn_state_e;

    localparam int TIMEOUT_CYCLES_DEF = 4095;
    localparam int PHASE_CNT_W        = 16;

    typedef struct packed {
        logic load_done;
        logic l1_done;
        logic l2_done;
        logic l3_done;
    } bnn_done_t;

    typedef struct packed {
        logic layer_clr_n;
        logic busy;
        logic result_valid;
        logic error;
    } bnn_status_t;

    function automatic logic is_active(bnn_state_e s);
        return (s == ST_LOAD) || (s == ST_LAYER_1) ||
               (s == ST_LAYER_2) || (s == ST_LAYER_3);
    endfunction

    function automatic bnn_state_e next_phase(bnn_state_e s);
        bnn_state_e n;
        n = ST_IDLE;
        case (s)
            ST_LOAD:    n = ST_LAYER_1;
            ST_LAYER_1: n = ST_LAYER_2;
            ST_LAYER_2: n = ST_LAYER_3;
            ST_LAYER_3: n = ST_DONE;
            default:    n = ST_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bnn_sequencer_if.sv
// Control/status bundle between the inference host/engines (master) and the
// phase sequencer (slave).
interface bnn_sequencer_if;
    import bnn_pkg::*;

    logic                   start;
    logic                   abort;
    logic                   load_done;
    logic                   l1_done;
    logic                   l2_done;
    logic                   l3_done;
    logic [2:0]             state;
    logic                   layer_clr_n;
    logic                   busy;
    logic                   result_valid;
    logic                   error;
    logic [PHASE_CNT_W-1:0] phase_cycles;

    modport master (
        output start, abort, load_done, l1_done, l2_done, l3_done,
        input  state, layer_clr_n, busy, result_valid, error, phase_cycles
    );

    modport slave (
        input  start, abort, load_done, l1_done, l2_done, l3_done,
        output state, layer_clr_n, busy, result_valid, error, phase_cycles
    );
endinterface

// File: rtl/bnn_sequencer_phase_timer.sv
// Per-phase cycle counter with saturation and a timeout compare against the
// configured per-phase budget.
module phase_timer
    import bnn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   en,
    output logic [PHASE_CNT_W-1:0] count,
    output logic                   timeout
);
    localparam int unsigned LIMIT = TIMEOUT_CYCLES - 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // >= rather than == so a saturated count can never slip past the limit
    assign timeout = en && (32'(count) >= LIMIT);
endmodule

// File: rtl/bnn_sequencer.sv
// Top-level phase sequencer for one BNN inference: LOAD -> LAYER_1..3 -> DONE,
// with per-phase timeout, abort, and registered status outputs.
module bnn_sequencer
    import bnn_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    bnn_sequencer_if.slave bus
);
    bnn_state_e             st_q, st_d;
    bnn_status_t            stat_q, stat_d;
    bnn_done_t              done;
    logic                   phase_done;
    logic                   timeout;
    logic                   phase_clr;
    logic                   phase_en;
    logic [PHASE_CNT_W-1:0] phase_cnt;

    assign done = '{load_done: bus.load_done, l1_done: bus.l1_done,
                    l2_done:   bus.l2_done,   l3_done: bus.l3_done};

    // Only the active phase's own done flag counts; the others may be stale.
    always_comb begin
        phase_done = 1'b0;
        case (st_q)
            ST_LOAD:    phase_done = done.load_done;
            ST_LAYER_1: phase_done = done.l1_done;
            ST_LAYER_2: phase_done = done.l2_done;
            ST_LAYER_3: phase_done = done.l3_done;
            default:    phase_done = 1'b0;
        endcase
    end

    always_comb begin
        st_d   = st_q;
        stat_d = '0;
        if (bus.abort) begin
            st_d = ST_IDLE;
        end else begin
            case (st_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.start) st_d = ST_LOAD;
                end
                ST_LOAD, ST_LAYER_1, ST_LAYER_2, ST_LAYER_3: begin
                    if (phase_done)   st_d = next_phase(st_q);
                    else if (timeout) st_d = ST_ERROR;
                end
                default: st_d = ST_IDLE;
            endcase
        end
        // Status is computed from the next state so the registered outputs
        // line up with the state register.
        stat_d.busy         = is_active(st_d);
        stat_d.result_valid = (st_d == ST_DONE);
        stat_d.error        = (st_d == ST_ERROR);
        stat_d.layer_clr_n  = !(bus.abort || ((st_d == ST_LOAD) && (st_q != ST_LOAD)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            stat_q <= '0;
        end else begin
            st_q   <= st_d;
            stat_q <= stat_d;
        end
    end

    assign phase_clr = (st_d != st_q);
    assign phase_en  = is_active(st_q);

    phase_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (phase_clr),
        .en      (phase_en),
        .count   (phase_cnt),
        .timeout (timeout)
    );

    assign bus.state        = st_q;
    assign bus.layer_clr_n  = stat_q.layer_clr_n;
    assign bus.busy         = stat_q.busy;
    assign bus.result_valid = stat_q.result_valid;
    assign bus.error        = stat_q.error;
    assign bus.phase_cycles = phase_cnt;
endmodule

// File: doc/bnn_sequencer.md
BNN_SEQUENCER -- requirements
Module: bnn_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 4095, maximum cycles allowed per phase before the block flags an error.
REQ-002 Port: clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 Port: rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 Port: start, input, 1, request one inference; sampled level, accepted only in IDLE, DONE or ERROR.
REQ-005 Port: abort, input, 1, returns the block to IDLE from any state.
REQ-006 Ports: load_done, l1_done, l2_done, l3_done, inputs, 1 each, sticky done flags from the pixel loader and layer 1/2/3 engines.
REQ-007 Port: state, output, 3, phase code broadcast to all layer engines.
REQ-008 Port: layer_clr_n, output, 1, registered synchronous clear for the loader and layer engines, active-low.
REQ-009 Ports: busy, result_valid, error, outputs, 1 each, status flags.
REQ-010 Port: phase_cycles, output, 16, cycle count of the current or last phase; saturates at 16'hFFFF.

Function
REQ-011 State codes: IDLE=3'b000, LOAD=3'b001, LAYER_1=3'b010, LAYER_2=3'b011, LAYER_3=3'b100, DONE=3'b101, ERROR=3'b110. The state port drives the current code directly.
REQ-012 Transitions:
- IDLE, DONE or ERROR with start=1 -> LOAD.
- LOAD with load_done=1 -> LAYER_1.
- LAYER_1 with l1_done=1 -> LAYER_2.
- LAYER_2 with l2_done=1 -> LAYER_3.
- LAYER_3 with l3_done=1 -> DONE.
- Each transition takes effect on the next edge.
REQ-013 A done input is honoured only while its own phase is active; done flags asserted in other phases are ignored.
REQ-014 layer_clr_n is 0 for exactly the first cycle of LOAD and for the first cycle of IDLE entered via abort; it is 1 otherwise.
REQ-015 Phase counter: resets to 0 on every state change; increments each cycle in LOAD and LAYER_1..3; phase_cycles mirrors it.
REQ-016 Timeout: if the phase counter reaches TIMEOUT_CYCLES-1 in an active phase with that phase's done=0, the next state is ERROR and error=1.
REQ-017 Done and timeout in the same cycle: done wins.
REQ-018 ERROR holds, error=1, until start (-> LOAD, error cleared) or abort (-> IDLE, error cleared).
REQ-019 busy=1 exactly in LOAD and LAYER_1..3.
REQ-020 result_valid=1 exactly in DONE; DONE holds until start or abort.
REQ-021 abort has priority over every other input, including a simultaneous start or done; next state is IDLE.
REQ-022 start is ignored while busy=1; no queueing.
REQ-023 All outputs are registered; no combinational path from any input to any output.

Reset
REQ-024 rst_n=0 asynchronously forces: state=IDLE, layer_clr_n=0, busy=0, result_valid=0, error=0, phase counter=0, phase_cycles=0.
REQ-025 layer_clr_n rises on the first clock edge after rst_n deasserts.
REQ-026 Reset asserted mid-inference discards the run with no residual status.

Structure
REQ-027 State codes and TIMEOUT_CYCLES default live in a shared package, bnn_pkg, and are also used by the layer engines.
REQ-028 One sub-module, phase_timer, holds the counter, saturation logic and timeout compare; the FSM stays in bnn_sequencer.

Verification
REQ-029 Nominal run: pulse start in IDLE; assert each done 5 cycles into its phase. Required response:
- state sequence 001, 010, 011, 100, 101;
- layer_clr_n low only in the first LOAD cycle;
- phase_cycles=5 at each transition;
- result_valid=1 in DONE.
REQ-030 Timeout: set TIMEOUT_CYCLES=16 and withhold l2_done -> ERROR entered 16 cycles after LAYER_2 entry, error=1, busy=0.
REQ-031 Collisions:
- l1_done at the timeout cycle -> LAYER_2, no error.
- abort and start in the same cycle in DONE -> IDLE.
REQ-032 Stale done: l3_done held high from reset -> sequence still stops in LAYER_1 until l1_done, and only then advances through LAYER_2 and LAYER_3.
REQ-033 Async reset mid-LAYER_2 between edges -> outputs reach their reset values immediately, without waiting for a clock edge.
REQ-034 Restart: start in DONE -> LOAD with a one-cycle layer_clr_n pulse; start asserted during LAYER_1 -> no effect.
